magnet_controller: RTL
======================

Name: magnet_controller

Overview:
- Generates the doctor's `magnet_on` level that the machine-movement block uses to choose between push and pull behaviour.
- Toggles the magnet from a keyboard key.
- Meters a per-frame energy budget: drains while on, recharges while off, forces a cooldown when empty.
- Sits between the keyboard decoder and the machine-movement block; also drives the HUD energy bar.

Parameters:
- MAX_ENERGY, 100: full energy level, and the level after reset. Must be ≤ 127.
- DRAIN_IDLE, 1: energy removed per frame while on and not touching the machine.
- DRAIN_HOLD, 2: energy removed per frame while on and `collision_doc` = 1 (actively pulling).
- RECHARGE_FRAMES, 4: frames per +1 energy while off (IDLE or COOLDOWN).
- COOLDOWN_FRAMES, 30: frames the magnet is locked out after energy reaches 0.
- REFILL_AMOUNT, 50: energy added by one battery pickup.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- startOfFrame, in, 1: one-cycle pulse at frame start (30 Hz).
- magnet_key, in, 1: level of the magnet key (1 = pressed).
- collision_doc, in, 1: doctor touching machine this cycle.
- refill_pickup, in, 1: one-cycle pulse, battery collected.
- magnet_on, out, 1: magnet active (registered).
- energy_level, out, 7: current energy, 0..MAX_ENERGY.
- cooldown_active, out, 1: high while in COOLDOWN.
- magnet_empty, out, 1: energy_level == 0.

Behaviour:
- Reset (sync, active-high):
  - state = IDLE; energy = MAX_ENERGY; magnet_on = 0; cooldown_active = 0; magnet_empty = 0.
  - Cooldown counter and recharge counter = 0.
  - `key_prev` = 1, so a key held through reset does not toggle.
- Key edge: `key_rise` = magnet_key & ~key_prev. `key_prev` is registered every cycle.
- All outputs are registered. Each output reflects the state and energy computed in the previous cycle.
- IDLE (magnet_on = 0):
  - `key_rise` with energy > 0 → ACTIVE. magnet_on = 1 on the next clock edge.
  - `key_rise` with energy == 0 is ignored.
  - On startOfFrame: the recharge counter increments. When it reaches RECHARGE_FRAMES, it clears and energy += 1, saturating at MAX_ENERGY.
- ACTIVE (magnet_on = 1):
  - On startOfFrame: energy -= (collision_doc ? DRAIN_HOLD : DRAIN_IDLE), saturating at 0.
  - If the resulting energy is 0 → COOLDOWN: counter loaded with COOLDOWN_FRAMES, magnet_on = 0, cooldown_active = 1, all in the same register update.
  - Otherwise, `key_rise` → IDLE.
  - Entering ACTIVE clears the recharge counter. No recharge occurs in ACTIVE.
- COOLDOWN (magnet_on = 0, cooldown_active = 1):
  - `key_rise` is ignored.
  - On startOfFrame the counter decrements. When it reaches 0 → IDLE.
  - Recharge runs as in IDLE.
  - A refill does not shorten the cooldown.
- Refill:
  - refill_pickup adds REFILL_AMOUNT in any state.
  - When it coincides with drain or recharge, the update is energy_next = clamp(energy − drain + recharge + refill, 0, MAX_ENERGY). Compute in ≥ 9-bit signed arithmetic before clamping.
  - A refill that keeps energy_next > 0 in the same cycle as a drain prevents the COOLDOWN entry.
- Simultaneous `key_rise` and energy_next == 0 in ACTIVE: COOLDOWN wins.
- Reset mid-operation (any state): the reset values above apply at the next clock edge. The cooldown in progress is discarded.
- magnet_empty = (energy_level == 0), registered alongside energy.

Test Plan:
1. Toggle and idle drain: reset, pulse magnet_key at cycle 5 → magnet_on = 1 at cycle 6. Ten startOfFrame pulses with collision_doc = 0 → energy_level = 90. Second key press → magnet_on = 0 next cycle, energy_level stays 90.
2. Hold drain to empty, cooldown lockout:
   - Stimulus: ACTIVE from 100 with collision_doc = 1.
   - After 50 frames: energy 0, magnet_on = 0, cooldown_active = 1, magnet_empty = 1.
   - Key presses during cooldown produce no change.
   - After 30 frames: IDLE, energy = 7 (floor(30/4) recharges), magnet_empty = 0.
3. Recharge: IDLE at energy 40, 8 frames → 42. Further: IDLE at 99, 8 frames → 100 (saturated).
4. Refill:
   - Energy 70 + refill_pickup → 100.
   - ACTIVE at energy 1, startOfFrame + collision_doc + refill_pickup in the same cycle → energy 49, state stays ACTIVE.
5. Reset cases:
   - Hold magnet_key through reset and 20 cycles after → magnet_on stays 0. Release, then press → magnet_on = 1.
   - Assert reset during COOLDOWN → next cycle: IDLE, energy 100, cooldown_active = 0.
6. Coincident events: ACTIVE at energy 1 (DRAIN_IDLE), `key_rise` and startOfFrame in the same cycle → COOLDOWN, cooldown_active = 1, magnet_on = 0.

Source files
------------

// File: rtl/magnet_controller.sv
// magnet_controller: doctor's magnet on/off control with a per-frame energy
// budget. The magnet drains energy while on, recharges it while off, and
// locks itself out for a fixed number of frames once the energy runs dry.
//
// Inputs are plain levels and pulses, sampled on every rising clk edge; there
// is no valid/ready handshake. startOfFrame and refill_pickup count once per
// cycle they are high, and magnet_key acts on its rising edge only.
module magnet_controller #(
    parameter int MAX_ENERGY      = 100,
    parameter int DRAIN_IDLE      = 1,
    parameter int DRAIN_HOLD      = 2,
    parameter int RECHARGE_FRAMES = 4,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int REFILL_AMOUNT   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       magnet_key,
    input  logic       collision_doc,
    input  logic       refill_pickup,
    output logic       magnet_on,
    output logic [6:0] energy_level,
    output logic       cooldown_active,
    output logic       magnet_empty,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACTIVE   = 2'd1;
    localparam logic [1:0] S_COOLDOWN = 2'd2;

    localparam logic signed [9:0] MAX_S = 10'(MAX_ENERGY);

    logic [1:0] state_q, state_d;
    logic [6:0] energy_q, energy_d;
    logic [7:0] cd_cnt_q, cd_cnt_d;
    logic [7:0] rc_cnt_q, rc_cnt_d;
    logic       key_prev_q, key_prev_d;
    logic       magnet_on_q, magnet_on_d;
    logic       cooldown_q, cooldown_d;
    logic       empty_q, empty_d;

    logic              key_rise;
    logic signed [9:0] drain_amt;
    logic signed [9:0] recharge_amt;
    logic signed [9:0] refill_amt;
    logic signed [9:0] e_sum;

    // Next-state, energy arithmetic and registered output values.
    always_comb begin
        key_rise     = magnet_key & ~key_prev_q;
        key_prev_d   = magnet_key;
        state_d      = state_q;
        cd_cnt_d     = cd_cnt_q;
        rc_cnt_d     = rc_cnt_q;
        drain_amt    = '0;
        recharge_amt = '0;
        refill_amt   = refill_pickup ? 10'(REFILL_AMOUNT) : 10'sd0;

        // Recharge only while the magnet is off (idle or locked out).
        if (state_q != S_ACTIVE && startOfFrame) begin
            if (rc_cnt_q + 8'd1 >= 8'(RECHARGE_FRAMES)) begin
                rc_cnt_d     = 8'd0;
                recharge_amt = 10'sd1;
            end else begin
                rc_cnt_d = rc_cnt_q + 8'd1;
            end
        end

        if (state_q == S_ACTIVE && startOfFrame) begin
            drain_amt = collision_doc ? 10'(DRAIN_HOLD) : 10'(DRAIN_IDLE);
        end

        // Wide signed sum so a drain below zero or a refill past full can
        // be clamped cleanly in one step.
        e_sum = $signed({3'b000, energy_q}) - drain_amt + recharge_amt + refill_amt;
        if (e_sum[9]) begin
            energy_d = 7'd0;
        end else if (e_sum > MAX_S) begin
            energy_d = 7'(MAX_ENERGY);
        end else begin
            energy_d = e_sum[6:0];
        end

        case (state_q)
            S_IDLE: begin
                if (key_rise && energy_q != 7'd0) begin
                    state_d  = S_ACTIVE;
                    rc_cnt_d = 8'd0;
                end
            end
            S_ACTIVE: begin
                // Running dry beats a simultaneous key press.
                if (energy_d == 7'd0) begin
                    state_d  = S_COOLDOWN;
                    cd_cnt_d = 8'(COOLDOWN_FRAMES);
                end else if (key_rise) begin
                    state_d = S_IDLE;
                end
            end
            S_COOLDOWN: begin
                if (startOfFrame) begin
                    if (cd_cnt_q <= 8'd1) begin
                        cd_cnt_d = 8'd0;
                        state_d  = S_IDLE;
                    end else begin
                        cd_cnt_d = cd_cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        magnet_on_d = (state_d == S_ACTIVE);
        cooldown_d  = (state_d == S_COOLDOWN);
        empty_d     = (energy_d == 7'd0);
    end

    // State and output registers; key_prev resets high so a held key is not a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            energy_q    <= 7'(MAX_ENERGY);
            cd_cnt_q    <= 8'd0;
            rc_cnt_q    <= 8'd0;
            key_prev_q  <= 1'b1;
            magnet_on_q <= 1'b0;
            cooldown_q  <= 1'b0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            energy_q    <= energy_d;
            cd_cnt_q    <= cd_cnt_d;
            rc_cnt_q    <= rc_cnt_d;
            key_prev_q  <= key_prev_d;
            magnet_on_q <= magnet_on_d;
            cooldown_q  <= cooldown_d;
            empty_q     <= empty_d;
        end
    end

    assign magnet_on       = magnet_on_q;
    assign energy_level    = energy_q;
    assign cooldown_active = cooldown_q;
    assign magnet_empty    = empty_q;
    assign state_dbg       = state_q;

endmodule
